// File: rtl/argmax_pkg.sv
// Shared types and defaults for the sequential arg-max classifier stage.
package argmax_pkg;

    localparam int unsigned DEFAULT_CLASSES = 10;
    localparam int unsigned DEFAULT_SCORE_W = 16;
    localparam int unsigned DEFAULT_IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Beat counter must reach NUM_CLASSES without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/argmax_sequencer_max_select.sv
// Unsigned compare-select; b replaces a only when strictly greater.
module max_select #(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic [SCORE_W-1:0] a,
    input  logic [IDX_W-1:0]   a_idx,
    input  logic [SCORE_W-1:0] b,
    input  logic [IDX_W-1:0]   b_idx,
    output logic [SCORE_W-1:0] m,
    output logic [IDX_W-1:0]   m_idx
);

    logic b_wins;

    always_comb begin
        b_wins = (b > a);
        m      = b_wins ? b : a;
        m_idx  = b_wins ? b_idx : a_idx;
    end

endmodule

// File: rtl/argmax_sequencer.sv
// Time-shared arg-max over NUM_CLASSES streamed scores; result offered on a
// valid/ready port after exactly NUM_CLASSES accepted beats.
module argmax_sequencer
    import argmax_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DEFAULT_CLASSES,
    parameter int unsigned SCORE_W     = DEFAULT_SCORE_W,
    parameter int unsigned IDX_W       = DEFAULT_IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] in_score,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] out_max,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_err,
    output logic               busy
);

    localparam int unsigned      CNT_W    = cnt_width(NUM_CLASSES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_CLASSES);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [SCORE_W-1:0] max_r;
    logic [IDX_W-1:0]   idx_r;
    logic               err_r;

    logic               beat_c;
    logic               final_c;
    logic               start_go_c;
    logic [SCORE_W-1:0] sel_max;
    logic [IDX_W-1:0]   sel_idx;

    max_select #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_max_select (
        .a     (max_r),
        .a_idx (idx_r),
        .b     (in_score),
        .b_idx (IDX_W'(cnt)),
        .m     (sel_max),
        .m_idx (sel_idx)
    );

    // Handshake qualifiers; abort suppresses any datapath update.
    always_comb begin
        beat_c     = (state == ACCUM) && in_valid && in_ready && !abort;
        final_c    = beat_c && (cnt == LAST_CNT);
        start_go_c = (state == IDLE) && start && !abort;
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go_c) state_nxt = ACCUM;
            ACCUM:   if (final_c)    state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // State register plus state-decoded outputs registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ACCUM);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Running maximum, index, beat count and framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            max_r <= '0;
            idx_r <= '0;
            err_r <= 1'b0;
        end else if (start_go_c) begin
            cnt   <= '0;
            max_r <= '0;
            idx_r <= '0;
            err_r <= 1'b0;
        end else if (beat_c) begin
            if (cnt == '0) begin
                max_r <= in_score;
                idx_r <= '0;
            end else begin
                max_r <= sel_max;
                idx_r <= sel_idx;
            end
            if (cnt != MAX_CNT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if ((in_last && (cnt < LAST_CNT)) || (!in_last && (cnt == LAST_CNT))) begin
                err_r <= 1'b1;
            end
        end
    end

    assign out_max = max_r;
    assign out_idx = idx_r;
    assign out_err = err_r;

endmodule
